// File: rtl/aes_pkg.sv
// Shared AES definitions: GF(2^8) arithmetic, affine maps, row shifts.
// Byte k of a [0:127] state is bits [8k:8k+7], row k%4, column k/4.
package aes_pkg;

  localparam logic [7:0] AES_POLY = 8'h1B;
  localparam logic [7:0] AFFINE_C = 8'h63;
  localparam logic [7:0] INV_AFF_C = 8'h05;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } ss_state_e;

  function automatic logic [7:0] gf_mul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ AES_POLY)
               : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  // a^254 == a^-1 for a != 0, and maps 0 to 0
  function automatic logic [7:0] gf_inv(
    input logic [7:0] a
  );
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = a;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(
    input logic [7:0] a,
    input int         n
  );
    return (a << n) | (a >> (8 - n));
  endfunction

  function automatic logic [7:0] affine(
    input logic [7:0] a
  );
    return a ^ rotl8(a, 1) ^ rotl8(a, 2)
             ^ rotl8(a, 3) ^ rotl8(a, 4)
             ^ AFFINE_C;
  endfunction

  function automatic logic [7:0] inv_affine(
    input logic [7:0] a
  );
    return rotl8(a, 1) ^ rotl8(a, 3)
         ^ rotl8(a, 6) ^ INV_AFF_C;
  endfunction

  function automatic logic [0:127] shift_rows(
    input logic [0:127] s
  );
    logic [0:127] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[8*(4*c+r) +: 8] = s[8*(4*((c+r)%4)+r) +: 8];
    return o;
  endfunction

  function automatic logic [0:127] inv_shift_rows(
    input logic [0:127] s
  );
    logic [0:127] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[8*(4*c+r) +: 8] = s[8*(4*((c+4-r)%4)+r) +: 8];
    return o;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Arithmetic AES S-box: forward (inverse then affine) or
// inverse (inverse affine then inverse), no tables.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] in_i,
  input  logic       mode_i,
  output logic [7:0] out_o
);

  logic [7:0] pre;
  logic [7:0] inv;

  assign pre   = mode_i ? inv_affine(in_i) : in_i;
  assign inv   = gf_inv(pre);
  assign out_o = mode_i ? inv : affine(inv);

endmodule

// File: rtl/sub_shift_stage.sv
// Iterative SubBytes+ShiftRows / InvShiftRows+InvSubBytes stage
// using LANES shared S-boxes over 16/LANES cycles.
module sub_shift_stage
  import aes_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_mode,
  input  logic [0:127] data_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] data_out
);

  localparam int NCYC = 16 / LANES;
  localparam logic [1:0] LAST = 2'(NCYC - 1);

  ss_state_e    state_q, state_d;
  logic [0:127] st_q, st_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         mode_q, mode_d;
  logic         ov_q, ov_d;

  logic [7:0] sb_in  [LANES];
  logic [7:0] sb_out [LANES];

  function automatic logic [6:0] bit_base(
    input logic [1:0] c,
    input int         l
  );
    return 7'((int'(c) * LANES + l) * 8);
  endfunction

  for (genvar g = 0; g < LANES; g++) begin : g_sb
    aes_sbox u_sb (
      .in_i  (sb_in[g]),
      .mode_i(mode_q),
      .out_o (sb_out[g])
    );
  end

  always_comb begin
    for (int l = 0; l < LANES; l++)
      sb_in[l] = st_q[bit_base(cnt_q, l) +: 8];
  end

  assign in_ready = (state_q == IDLE)
                 || (state_q == DONE && out_ready);
  assign out_valid = ov_q;
  assign data_out  = mode_q ? st_q : shift_rows(st_q);

  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    ov_d    = ov_q;
    unique case (state_q)
      SUB: begin
        for (int l = 0; l < LANES; l++)
          st_d[bit_base(cnt_q, l) +: 8] = sb_out[l];
        if (cnt_q == LAST) begin
          state_d = DONE;
          ov_d    = 1'b1;
          cnt_d   = 2'd0;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          ov_d    = 1'b0;
        end
      end
      default: ;
    endcase
    // accept can overlap the output handshake in DONE
    if (in_valid && in_ready) begin
      st_d    = in_mode ? inv_shift_rows(data_in)
                        : data_in;
      mode_d  = in_mode;
      cnt_d   = 2'd0;
      state_d = SUB;
      ov_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      st_q    <= '0;
      cnt_q   <= 2'd0;
      mode_q  <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      ov_q    <= ov_d;
    end
  end

endmodule

// File: tb/tb_sub_shift_stage.sv
// Directed bench for sub_shift_stage with LANES = 4, 8, 16.
module tb_sub_shift_stage;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         mode = 1'b0;
  logic [0:127] din = '0;
  logic         iv   [3];
  logic         ir   [3];
  logic         ov   [3];
  logic         ordy [3];
  logic [0:127] dout [3];

  int tests = 0;
  int fails = 0;

  localparam logic [0:127] V1_IN  =
    128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [0:127] V1_OUT =
    128'hd4bf5d30e0b452aeb84111f11e2798e5;

  always #5 clk = ~clk;

  sub_shift_stage #(.LANES(4)) u4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[0]), .in_ready(ir[0]),
    .in_mode(mode), .data_in(din),
    .out_valid(ov[0]), .out_ready(ordy[0]),
    .data_out(dout[0])
  );

  sub_shift_stage #(.LANES(8)) u8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[1]), .in_ready(ir[1]),
    .in_mode(mode), .data_in(din),
    .out_valid(ov[1]), .out_ready(ordy[1]),
    .data_out(dout[1])
  );

  sub_shift_stage #(.LANES(16)) u16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[2]), .in_ready(ir[2]),
    .in_mode(mode), .data_in(din),
    .out_valid(ov[2]), .out_ready(ordy[2]),
    .data_out(dout[2])
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bit(input string nm,
                         input logic got,
                         input logic exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %b exp %b", nm, got, exp);
    end
  endtask

  task automatic chk_vec(input string nm,
                         input logic [0:127] got,
                         input logic [0:127] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h exp %h", nm, got, exp);
    end
  endtask

  // accept one block on DUT s, measure latency, check, drain
  task automatic run_vec(input int s,
                         input logic [0:127] d,
                         input logic m,
                         input logic [0:127] exp,
                         input int lat,
                         input string nm);
    int n;
    din   = d;
    mode  = m;
    iv[s] = 1'b1;
    step();
    iv[s] = 1'b0;
    din   = '0;
    mode  = ~m;
    n = 0;
    while (!ov[s] && n < 20) begin
      step();
      n++;
    end
    tests++;
    if (n != lat) begin
      fails++;
      $display("FAIL %s_lat: got %0d exp %0d", nm, n, lat);
    end
    chk_vec({nm, "_data"}, dout[s], exp);
    step();
    chk_bit({nm, "_drain"}, ov[s], 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    chk_bit("rst_ov", ov[0], 1'b0);
    chk_vec("rst_dout", dout[0], '0);
    chk_bit("rst_ir", ir[0], 1'b1);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_fips();
    run_vec(0, V1_IN, 1'b0, V1_OUT, 4, "fwd_v1");
    run_vec(0, V1_OUT, 1'b1, V1_IN, 4, "inv_v1");
  endtask

  task automatic test_corners();
    run_vec(0, {16{8'h00}}, 1'b0, {16{8'h63}}, 4, "sb_00");
    run_vec(0, {16{8'h53}}, 1'b0, {16{8'hed}}, 4, "sb_53");
    run_vec(0, {16{8'hff}}, 1'b0, {16{8'h16}}, 4, "sb_ff");
    run_vec(0, {16{8'h63}}, 1'b1, {16{8'h00}}, 4, "isb_63");
  endtask

  task automatic test_backpressure();
    int n;
    logic stable;
    logic busy;
    ordy[0] = 1'b0;
    din   = V1_IN;
    mode  = 1'b0;
    iv[0] = 1'b1;
    step();
    iv[0] = 1'b0;
    n = 0;
    while (!ov[0] && n < 20) begin
      step();
      n++;
    end
    chk_bit("bp_ov", ov[0], 1'b1);
    stable = 1'b1;
    busy = 1'b0;
    for (int i = 0; i < 10; i++) begin
      din   = {16{8'(i)}};
      mode  = 1'(i);
      iv[0] = 1'(i % 2);
      if (ir[0] !== 1'b0) busy = 1'b1;
      step();
      if (dout[0] !== V1_OUT || ov[0] !== 1'b1)
        stable = 1'b0;
    end
    iv[0] = 1'b0;
    chk_bit("bp_stable", stable, 1'b1);
    chk_bit("bp_inrdy_low", busy, 1'b0);
    chk_vec("bp_hold", dout[0], V1_OUT);
    ordy[0] = 1'b1;
    din   = {16{8'h00}};
    mode  = 1'b0;
    iv[0] = 1'b1;
    #1;
    chk_bit("bp_inrdy_pass", ir[0], 1'b1);
    step();
    iv[0] = 1'b0;
    chk_bit("bp_swap_ov", ov[0], 1'b0);
    n = 0;
    while (!ov[0] && n < 20) begin
      step();
      n++;
    end
    tests++;
    if (n != 4) begin
      fails++;
      $display("FAIL bp2_lat: got %0d exp 4", n);
    end
    chk_vec("bp2_data", dout[0], {16{8'h63}});
    step();
  endtask

  task automatic test_reset_mid();
    din   = V1_IN;
    mode  = 1'b0;
    iv[0] = 1'b1;
    step();
    iv[0] = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    step();
    chk_bit("mid_ov", ov[0], 1'b0);
    chk_vec("mid_dout", dout[0], '0);
    chk_bit("mid_ir", ir[0], 1'b1);
    rst_n = 1'b1;
    step();
    run_vec(0, V1_IN, 1'b0, V1_OUT, 4, "mid_rerun");
  endtask

  task automatic test_lanes();
    run_vec(1, V1_IN, 1'b0, V1_OUT, 2, "l8_fwd");
    run_vec(2, V1_IN, 1'b0, V1_OUT, 1, "l16_fwd");
    run_vec(2, V1_OUT, 1'b1, V1_IN, 1, "l16_inv");
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      iv[i]   = 1'b0;
      ordy[i] = 1'b1;
    end
    test_reset();
    test_fips();
    test_corners();
    test_backpressure();
    test_reset_mid();
    test_lanes();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
